// File: rtl/vga_entity_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_entity_map_pkg                                                   |
// | Shared constants, entity codes and FSM encoding for the entity map.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_entity_map_pkg;

    localparam int DEF_H_CELLS   = 40;
    localparam int DEF_V_CELLS   = 30;
    localparam int DEF_CELL_LOG2 = 4;
    localparam int ADDR_W        = 11;
    localparam int DEPTH         = 2048;
    localparam int ENT_W         = 2;

    typedef enum logic [1:0] {
        ENT_APPLE   = 2'd0,
        ENT_HEAD    = 2'd1,
        ENT_TAIL    = 2'd2,
        ENT_NOTHING = 2'd3
    } ent_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Row-major cell address; callers mask out-of-grid cells themselves.
    function automatic logic [ADDR_W-1:0] cell_addr(input int cx, input int cy, input int h_cells);
        return ADDR_W'(cy * h_cells + cx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_entity_map_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_entity_map_ram                                                   |
// | One cell bank: 1W1R synchronous RAM with registered read data.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_entity_map_ram
    import vga_entity_map_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [ENT_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [ENT_W-1:0]  o_rdata
);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [ENT_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vga_entity_map.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_entity_map                                                       |
// | Double-buffered entity grid: game writes back bank, display reads    |
// | front bank; banks swap only on a frame tick while idle.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_entity_map
    import vga_entity_map_pkg::*;
#(
    parameter int H_CELLS   = DEF_H_CELLS,
    parameter int V_CELLS   = DEF_V_CELLS,
    parameter int CELL_LOG2 = DEF_CELL_LOG2
) (
    input  logic             iVGA_CLK,
    input  logic             sys_reset_n,
    input  logic [9:0]       ipix_x,
    input  logic [9:0]       ipix_y,
    output logic [ENT_W-1:0] ent,
    input  logic             iframe_tick,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [5:0]       wr_cx,
    input  logic [4:0]       wr_cy,
    input  logic [ENT_W-1:0] wr_ent,
    input  logic             clr_req,
    input  logic             swap_req,
    output logic             busy,
    output logic             swap_done
);

    localparam int                c_cell_w    = 10 - CELL_LOG2;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(H_CELLS * V_CELLS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_front_sel;
    logic              r_swap_pend;
    logic              r_swap_done;
    logic              r_busy;
    logic              r_wr_ready;
    logic              r_rd_oob;
    logic              r_rd_sel;

    logic [c_cell_w-1:0] w_rd_cx;
    logic [c_cell_w-1:0] w_rd_cy;
    logic                w_rd_oob;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_wr_fire;
    logic                w_wr_in_grid;
    logic                w_swap_take;
    logic [1:0]          w_we;
    logic [1:0]          w_we_back;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ENT_W-1:0]    w_wdata;
    logic [ENT_W-1:0]    w_rdata [2];
    logic                w_unused;

    // Sub-cell pixel bits never affect the lookup.
    assign w_unused  = ^{ipix_x[CELL_LOG2-1:0], ipix_y[CELL_LOG2-1:0]};

    assign w_rd_cx   = ipix_x[9:CELL_LOG2];
    assign w_rd_cy   = ipix_y[9:CELL_LOG2];
    assign w_rd_oob  = (int'(w_rd_cx) >= H_CELLS) || (int'(w_rd_cy) >= V_CELLS);
    assign w_rd_addr = cell_addr(int'(w_rd_cx), int'(w_rd_cy), H_CELLS);

    assign w_wr_addr    = cell_addr(int'(wr_cx), int'(wr_cy), H_CELLS);
    assign w_wr_in_grid = (int'(wr_cx) < H_CELLS) && (int'(wr_cy) < V_CELLS);
    assign w_wr_fire    = wr_valid && r_wr_ready;
    assign w_swap_take  = iframe_tick && r_swap_pend && (r_state == ST_IDLE);
    assign w_we_back    = r_front_sel ? 2'b01 : 2'b10;

    always_comb begin
        w_we    = 2'b00;
        w_waddr = w_wr_addr;
        w_wdata = wr_ent;
        case (r_state)
            ST_INIT: begin
                w_we    = 2'b11;
                w_waddr = r_addr;
                w_wdata = ENT_NOTHING;
            end
            ST_CLEAR: begin
                w_we    = w_we_back;
                w_waddr = r_addr;
                w_wdata = ENT_NOTHING;
            end
            ST_IDLE: begin
                if (w_wr_fire && w_wr_in_grid) begin
                    w_we = w_we_back;
                end
            end
            default: ;
        endcase
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        vga_entity_map_ram u_ram (
            .clk     (iVGA_CLK),
            .i_we    (w_we[b]),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (w_rd_addr),
            .o_rdata (w_rdata[b])
        );
    end

    always_ff @(posedge iVGA_CLK or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state     <= ST_INIT;
            r_addr      <= '0;
            r_busy      <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_front_sel <= 1'b0;
            r_swap_pend <= 1'b0;
            r_swap_done <= 1'b0;
            r_rd_oob    <= 1'b1;
            r_rd_sel    <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            r_rd_oob    <= w_rd_oob;
            r_rd_sel    <= r_front_sel;

            case (r_state)
                ST_INIT, ST_CLEAR: begin
                    if (r_addr == c_last_addr) begin
                        r_state    <= ST_IDLE;
                        r_addr     <= '0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 11'd1;
                    end
                end
                ST_IDLE: begin
                    // A write accepted on this edge lands before the sweep starts.
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_addr     <= '0;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_addr  <= '0;
                end
            endcase

            // A request coinciding with the tick only arms the next tick.
            if (w_swap_take) begin
                r_front_sel <= ~r_front_sel;
                r_swap_pend <= 1'b0;
                r_swap_done <= 1'b1;
            end else if (swap_req) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    assign ent       = r_rd_oob ? ENT_NOTHING : w_rdata[r_rd_sel];
    assign wr_ready  = r_wr_ready;
    assign busy      = r_busy;
    assign swap_done = r_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_entity_map.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_entity_map                                                    |
// | Randomized scoreboard bench for the double-buffered entity map.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_entity_map;

    logic       clk = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic [9:0] ipix_x = '0;
    logic [9:0] ipix_y = '0;
    logic [1:0] ent;
    logic       iframe_tick = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_cx = '0;
    logic [4:0] wr_cy = '0;
    logic [1:0] wr_ent = '0;
    logic       clr_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       busy;
    logic       swap_done;
    logic       probe_v = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int x; int y; int e; } probe_t;
    probe_t exp_q[$];

    // Reference: [bank][column][row] cell contents plus displayed bank.
    int mcell [2][40][30];
    int mfront;

    always #5 clk = ~clk;

    vga_entity_map dut (
        .iVGA_CLK    (clk),
        .sys_reset_n (sys_reset_n),
        .ipix_x      (ipix_x),
        .ipix_y      (ipix_y),
        .ent         (ent),
        .iframe_tick (iframe_tick),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_cx       (wr_cx),
        .wr_cy       (wr_cy),
        .wr_ent      (wr_ent),
        .clr_req     (clr_req),
        .swap_req    (swap_req),
        .busy        (busy),
        .swap_done   (swap_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int model_ent(input int x, input int y);
        int cx = x / 16;
        int cy = y / 16;
        if (cx < 40 && cy < 30) return mcell[mfront][cx][cy];
        return 3;
    endfunction

    function automatic void model_write(input int cx, input int cy, input int e);
        if (cx < 40 && cy < 30) mcell[1 - mfront][cx][cy] = e;
    endfunction

    function automatic void model_clear();
        for (int cx = 0; cx < 40; cx++)
            for (int cy = 0; cy < 30; cy++)
                mcell[1 - mfront][cx][cy] = 3;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int cx = 0; cx < 40; cx++)
                for (int cy = 0; cy < 30; cy++)
                    mcell[b][cx][cy] = 3;
        mfront = 0;
    endfunction

    // Monitor: a probe sampled at a rising edge is compared one cycle later.
    initial begin
        forever begin
            bit     v;
            probe_t p;
            @(posedge clk);
            v = probe_v;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 0, 1);
                end else begin
                    p = exp_q.pop_front();
                    check($sformatf("ent(%0d,%0d)", p.x, p.y), int'(ent), p.e);
                end
            end
        end
    end

    task automatic probe(input int x, input int y);
        probe_t p;
        @(negedge clk);
        ipix_x  = 10'(x);
        ipix_y  = 10'(y);
        probe_v = 1'b1;
        p.x = x; p.y = y; p.e = model_ent(x, y);
        exp_q.push_back(p);
    endtask

    task automatic probe_end();
        @(negedge clk);
        probe_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic full_scan();
        for (int cy = 0; cy < 30; cy++)
            for (int cx = 0; cx < 40; cx++)
                probe(cx * 16 + int'($urandom_range(15)), cy * 16 + int'($urandom_range(15)));
        probe(640, 0);
        probe(0, 480);
        probe(1023, 1023);
        probe_end();
    endtask

    task automatic do_write(input int cx, input int cy, input int e);
        @(negedge clk);
        check("wr_ready_before_write", int'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_cx    = 6'(cx);
        wr_cy    = 5'(cy);
        wr_ent   = 2'(e);
        model_write(cx, cy, e);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        iframe_tick = 1'b1;
        @(negedge clk);
        iframe_tick = 1'b0;
        check("swap_done_pulse", int'(swap_done), 1);
        mfront = 1 - mfront;
        @(negedge clk);
        check("swap_done_single", int'(swap_done), 0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int cyc;
        int nsd;

        model_reset();

        // Reset values and the power-up sweep
        repeat (3) @(negedge clk);
        check("rst_ent", int'(ent), 3);
        check("rst_busy", int'(busy), 1);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_swap_done", int'(swap_done), 0);
        sys_reset_n = 1'b1;
        wait_idle(cyc);
        check("init_busy_cycles", cyc, 1200);
        check("init_wr_ready", int'(wr_ready), 1);
        full_scan();

        // Apple at (5,2) becomes visible after a swap
        do_write(5, 2, 0);
        do_swap();
        for (int x = 78; x <= 97; x++) begin
            probe(x, 31); probe(x, 32); probe(x, 40); probe(x, 47); probe(x, 48);
        end
        probe_end();
        full_scan();

        // Head in the last cell stays hidden until swapped in
        do_write(39, 29, 1);
        for (int x = 622; x <= 639; x++) begin
            probe(x, 464); probe(x, 479);
        end
        probe_end();
        do_swap();
        for (int x = 622; x <= 639; x++) begin
            probe(x, 463); probe(x, 464); probe(x, 479);
        end
        probe_end();
        full_scan();

        // Clear together with a write; swap requested mid-clear
        @(negedge clk);
        wr_valid = 1'b1; wr_cx = 6'd0; wr_cy = 5'd0; wr_ent = 2'd2; clr_req = 1'b1;
        model_write(0, 0, 2);
        model_clear();
        @(negedge clk);
        wr_valid = 1'b0; clr_req = 1'b0;
        check("clr_busy", int'(busy), 1);
        check("clr_wr_ready", int'(wr_ready), 0);
        cyc = 0; nsd = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100) swap_req = 1'b1;
            if (cyc == 101) swap_req = 1'b0;
            if (cyc == 300) iframe_tick = 1'b1;
            if (cyc == 301) iframe_tick = 1'b0;
            if (swap_done) nsd++;
        end
        check("clr_busy_cycles", cyc, 1200);
        check("clr_no_swap_during_clear", nsd, 0);
        check("clr_wr_ready_after", int'(wr_ready), 1);
        nsd = 0;
        repeat (5) begin
            @(negedge clk);
            if (swap_done) nsd++;
        end
        check("clr_no_swap_without_tick", nsd, 0);
        @(negedge clk);
        iframe_tick = 1'b1;
        @(negedge clk);
        iframe_tick = 1'b0;
        check("deferred_swap_done", int'(swap_done), 1);
        mfront = 1 - mfront;
        @(negedge clk);
        check("deferred_swap_single", int'(swap_done), 0);
        probe(0, 0); probe(15, 15); probe(16, 0);
        probe_end();
        full_scan();

        // Out-of-grid writes complete the handshake and are dropped
        do_write(45, 3, 1);
        do_write(5, 31, 2);
        do_write(63, 31, 0);
        do_swap();
        probe(700, 100); probe(700, 0); probe(100, 500);
        probe_end();
        full_scan();

        // Randomized writes, swap, randomized reads
        for (int i = 0; i < 60; i++)
            do_write(int'($urandom_range(47)), int'($urandom_range(31)), int'($urandom_range(3)));
        do_swap();
        for (int i = 0; i < 300; i++)
            probe(int'($urandom_range(1023)), int'($urandom_range(1023)));
        probe_end();
        full_scan();

        // Reset in the middle of a clear, with a swap pending
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 1; i < 600; i++) begin
            @(negedge clk);
            swap_req = (i == 10);
        end
        sys_reset_n = 1'b0;
        model_reset();
        #1;
        check("rst2_ent", int'(ent), 3);
        check("rst2_busy", int'(busy), 1);
        check("rst2_wr_ready", int'(wr_ready), 0);
        check("rst2_swap_done", int'(swap_done), 0);
        repeat (3) @(negedge clk);
        sys_reset_n = 1'b1;
        wait_idle(cyc);
        check("rst2_init_cycles", cyc, 1200);
        @(negedge clk);
        iframe_tick = 1'b1;
        @(negedge clk);
        iframe_tick = 1'b0;
        check("rst2_pend_cleared", int'(swap_done), 0);
        @(negedge clk);
        check("rst2_pend_cleared_late", int'(swap_done), 0);
        do_write(1, 1, 2);
        full_scan();
        do_swap();
        full_scan();

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
